// File: rtl/data_mem_access.sv
// Memory-access stage: runs a request/ready handshake for lw/sw, stalls the core
// until the access completes, and reports misaligned accesses and bus timeouts.
module data_mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ALUop_i,
    input  logic [31:0] ALUOut,
    input  logic [31:0] DataOutReg2,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic [31:0] ReadData_o,
    output logic        load_wb_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam logic [4:0] OP_LW     = 5'b10100;
    localparam logic [4:0] OP_SW     = 5'b10101;
    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wb_q, wb_d;
    logic        err_q, err_d;

    logic is_mem_s, aligned_s, accept_s, timeout_s;
    logic stall_s, misalign_s;

    assign is_mem_s  = (ALUop_i == OP_LW) || (ALUop_i == OP_SW);
    assign aligned_s = (ALUOut[1:0] == 2'b00);
    assign accept_s  = is_mem_s && aligned_s;
    // The WAIT cycle that would bring the count up to TIMEOUT is the last one.
    assign timeout_s = ((cnt_q + 8'd1) == TIMEOUT_W);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_ready_i || timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Combinational outputs: core stall and misalignment flag.
    always_comb begin
        stall_s    = 1'b0;
        misalign_s = 1'b0;
        if (rst) begin
            stall_s    = 1'b0;
            misalign_s = 1'b0;
        end else begin
            stall_s    = (state_q == S_WAIT) || ((state_q == S_IDLE) && accept_s);
            misalign_s = is_mem_s && !aligned_s;
        end
    end

    // Datapath next values: latch on accept, capture read data or time out in WAIT.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        wb_d    = 1'b0;
        err_d   = 1'b0;
        req_d   = (state_d == S_WAIT);
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    addr_d  = {ALUOut[31:2], 2'b00};
                    wdata_d = DataOutReg2;
                    we_d    = (ALUop_i == OP_SW);
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WAIT: begin
                if (mem_ready_i) begin
                    wb_d = !we_q;
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (timeout_s) begin
                        err_d = 1'b1;
                        if (!we_q) begin
                            rdata_d = 32'd0;
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        err_d = 1'b0;
                    end
                end
            end
            S_DONE:  cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath and registered-output storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            rdata_q <= 32'd0;
            wb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    assign stall_o     = stall_s;
    assign misalign_o  = misalign_s;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign ReadData_o  = rdata_q;
    assign load_wb_o   = wb_q;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: a transaction-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_data_mem_access;
    localparam int TMO = 4;
    localparam logic [4:0] LW  = 5'b10100;
    localparam logic [4:0] SW  = 5'b10101;
    localparam logic [4:0] ADD = 5'b01101;
    localparam logic [4:0] NOP = 5'b00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  alu_op = 5'd0;
    logic [31:0] alu_out = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        stall, req, we, wb, mis, berr;
    logic [31:0] addr, wdata, rdata_out;

    data_mem_access #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ALUop_i(alu_op), .ALUOut(alu_out), .DataOutReg2(rs2),
        .stall_o(stall), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr),
        .mem_wdata_o(wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .ReadData_o(rdata_out), .load_wb_o(wb), .misalign_o(mis), .bus_err_o(berr)
    );

    always #5 clk = ~clk;

    // Reference model: an access in flight counts its unanswered WAIT cycles.
    int          m_wait = -1;
    bit          m_done = 1'b0, m_wb = 1'b0, m_err = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_rd = 32'd0;

    function automatic bit is_mem(logic [4:0] op);
        return (op == LW) || (op == SW);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_wait <= -1; m_done <= 1'b0; m_wb <= 1'b0; m_err <= 1'b0; m_we <= 1'b0;
            m_addr <= 32'd0; m_wdata <= 32'd0; m_rd <= 32'd0;
        end else if (m_wait >= 0) begin
            if (mem_ready) begin
                if (!m_we) m_rd <= mem_rdata;
                m_done <= 1'b1; m_wb <= !m_we; m_err <= 1'b0; m_wait <= -1;
            end else if (m_wait + 1 == TMO) begin
                if (!m_we) m_rd <= 32'd0;
                m_done <= 1'b1; m_wb <= 1'b0; m_err <= 1'b1; m_wait <= -1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (m_done) begin
            m_done <= 1'b0; m_wb <= 1'b0; m_err <= 1'b0;
        end else if (is_mem(alu_op) && alu_out[1:0] == 2'b00) begin
            m_addr <= {alu_out[31:2], 2'b00}; m_wdata <= rs2; m_we <= (alu_op == SW);
            m_wait <= 0;
        end
    end

    int checks = 0;
    int failures = 0;
    int n_stall = 0, n_req = 0, n_wb = 0, n_err = 0, n_mis = 0;
    bit prev_req = 1'b0;
    logic [31:0] req_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit e_stall, e_req, e_mis;
        e_req   = (m_wait >= 0);
        e_stall = !rst && (e_req || (!m_done && is_mem(alu_op) && alu_out[1:0] == 2'b00));
        e_mis   = !rst && is_mem(alu_op) && alu_out[1:0] != 2'b00;
        chk("stall", 32'(stall), 32'(e_stall));
        chk("req", 32'(req), 32'(e_req));
        chk("we", 32'(we), 32'(m_we));
        chk("addr", addr, m_addr);
        chk("wdata", wdata, m_wdata);
        chk("readdata", rdata_out, m_rd);
        chk("load_wb", 32'(wb), 32'(m_done && m_wb));
        chk("bus_err", 32'(berr), 32'(m_done && m_err));
        chk("misalign", 32'(mis), 32'(e_mis));
        n_stall += int'(stall); n_req += int'(req); n_wb += int'(wb);
        n_err += int'(berr); n_mis += int'(mis);
        if (req && !prev_req) req_log.push_back(addr);
        prev_req = req;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for n cycles; ready pulses on cycle ready_at (0 = never).
    task automatic run_mem(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int ready_at, input int n);
        alu_op = op; alu_out = a; rs2 = d; mem_rdata = rd;
        for (int c = 0; c < n; c++) begin
            mem_ready = (ready_at != 0 && c == ready_at);
            cycle();
        end
        mem_ready = 1'b0; alu_op = NOP;
    endtask

    int s0, r0, w0, e0, m0;
    task automatic snap();
        s0 = n_stall; r0 = n_req; w0 = n_wb; e0 = n_err; m0 = n_mis;
    endtask

    initial begin
        #1;
        cycle(); cycle();
        chk("reset_readdata", rdata_out, 32'd0);
        chk("reset_req", 32'(req), 32'd0);
        rst = 1'b0;

        // Aligned lw, ready on first WAIT cycle.
        snap();
        run_mem(LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, 3);
        cycle();
        chk("lw_stall_cycles", 32'(n_stall - s0), 32'd2);
        chk("lw_wb_pulses", 32'(n_wb - w0), 32'd1);
        chk("lw_addr", addr, 32'h10);
        chk("lw_we", 32'(we), 32'd0);
        chk("lw_readdata", rdata_out, 32'hDEAD_BEEF);

        // sw with ready on the fourth WAIT cycle.
        snap();
        run_mem(SW, 32'h20, 32'h1234_5678, 32'h0, 4, 6);
        chk("sw_stall_cycles", 32'(n_stall - s0), 32'd5);
        chk("sw_req_cycles", 32'(n_req - r0), 32'd4);
        chk("sw_wb_pulses", 32'(n_wb - w0), 32'd0);
        chk("sw_we", 32'(we), 32'd1);
        chk("sw_wdata", wdata, 32'h1234_5678);

        // Misaligned lw.
        snap();
        run_mem(LW, 32'h22, 32'h0, 32'h5555_5555, 0, 2);
        chk("mis_cycles", 32'(n_mis - m0), 32'd2);
        chk("mis_stall", 32'(n_stall - s0), 32'd0);
        chk("mis_req", 32'(n_req - r0), 32'd0);
        chk("mis_readdata", rdata_out, 32'hDEAD_BEEF);

        // lw that never gets ready.
        snap();
        run_mem(LW, 32'h30, 32'h0, 32'hAAAA_AAAA, 0, 6);
        cycle();
        chk("tmo_req_cycles", 32'(n_req - r0), 32'd4);
        chk("tmo_err_pulses", 32'(n_err - e0), 32'd1);
        chk("tmo_wb_pulses", 32'(n_wb - w0), 32'd0);
        chk("tmo_readdata", rdata_out, 32'd0);

        // Reset on the second WAIT cycle of a sw.
        snap();
        alu_op = SW; alu_out = 32'h40; rs2 = 32'h0F0F_0F0F;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; alu_op = NOP;
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        cycle(); cycle();
        chk("rst_err_pulses", 32'(n_err - e0), 32'd0);
        chk("rst_wb_pulses", 32'(n_wb - w0), 32'd0);

        // Back-to-back lw, sw, then add.
        snap();
        req_log.delete();
        run_mem(LW, 32'h4, 32'h0, 32'hCAFE_0004, 1, 3);
        run_mem(SW, 32'h8, 32'h0BAD_F00D, 32'h0, 1, 3);
        chk("b2b_stall_cycles", 32'(n_stall - s0), 32'd4);
        s0 = n_stall;
        run_mem(ADD, 32'h10, 32'h0, 32'h0, 0, 2);
        chk("add_stall", 32'(n_stall - s0), 32'd0);
        chk("b2b_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() == 2) begin
            chk("b2b_first_addr", req_log[0], 32'h4);
            chk("b2b_second_addr", req_log[1], 32'h8);
        end
        chk("b2b_readdata", rdata_out, 32'hCAFE_0004);
        chk("b2b_wb_pulses", 32'(n_wb - w0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
